// File: rtl/aes_tb_pkg.sv
// Shared types, constants and helpers for the AES round-trip stimulus/checker engine.
package aes_tb_pkg;

    typedef logic         ulogic1;
    typedef logic [127:0] ulogic128;
    typedef logic [255:0] ulogic256;

    typedef enum logic [1:0] {
        KEY_AES128     = 2'd0,
        KEY_AES192     = 2'd1,
        KEY_AES256     = 2'd2,
        KEY_AES256_ALT = 2'd3
    } key_mode_t;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_GEN      = 4'd1,
        S_KEY      = 4'd2,
        S_ENC_REQ  = 4'd3,
        S_ENC_WAIT = 4'd4,
        S_DEC_REQ  = 4'd5,
        S_DEC_WAIT = 4'd6,
        S_CHECK    = 4'd7,
        S_DONE     = 4'd8
    } seq_state_t;

    localparam logic [31:0] SEED_DEFAULT = 32'h1;
    localparam int          GEN_WORDS    = 12;

    // Galois form: shift right, fold the taps back in when the bit shifted out is 1.
    function automatic logic [31:0] lfsr_next(input logic [31:0] value, input logic [31:0] poly);
        logic [31:0] result;
        result = value >> 1;
        if (value[0]) begin
            result = result ^ poly;
        end
        return result;
    endfunction

    function automatic ulogic256 mask_key(input ulogic256 key, input key_mode_t mode);
        ulogic256 result;
        result = key;
        case (mode)
            KEY_AES128: result[127:0] = '0;
            KEY_AES192: result[63:0]  = '0;
            default:    result        = key;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/aes_roundtrip_sequencer_if.sv
// Key-load, request and response channels between the sequencer and the AES core.
interface aes_roundtrip_sequencer_if;
    import aes_tb_pkg::*;

    ulogic1      key_valid;
    ulogic1      key_ready;
    ulogic256    key_out;
    logic [1:0]  key_len;
    ulogic1      req_valid;
    ulogic1      req_ready;
    ulogic1      req_decrypt;
    ulogic128    req_data;
    ulogic1      resp_valid;
    ulogic128    resp_data;

    modport master (
        output key_valid, key_out, key_len, req_valid, req_decrypt, req_data,
        input  key_ready, req_ready, resp_valid, resp_data
    );

    modport slave (
        input  key_valid, key_out, key_len, req_valid, req_decrypt, req_data,
        output key_ready, req_ready, resp_valid, resp_data
    );

endinterface

// File: rtl/aes_roundtrip_sequencer_lfsr.sv
// 32-bit Galois LFSR used as the stimulus source; a zero seed is replaced by the default seed.
module aes_lfsr32
    import aes_tb_pkg::*;
#(
    parameter logic [31:0] LFSR_POLY = 32'h80200003
) (
    input  logic        clk,
    input  logic        resetH,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        step,
    output logic [31:0] value
);

    always_ff @(posedge clk) begin
        if (resetH) begin
            value <= SEED_DEFAULT;
        end else if (load) begin
            value <= (load_value == 32'h0) ? SEED_DEFAULT : load_value;
        end else if (step) begin
            value <= lfsr_next(value, LFSR_POLY);
        end
    end

endmodule

// File: rtl/aes_roundtrip_sequencer.sv
// Self-contained AES stimulus/checker: generates key and plaintext, encrypts, decrypts, compares.
module aes_roundtrip_sequencer
    import aes_tb_pkg::*;
#(
    parameter int          NUM_VEC_W = 16,
    parameter int          TIMEOUT   = 1024,
    parameter logic [31:0] LFSR_POLY = 32'h80200003
) (
    input  logic                  clk,
    input  logic                  resetH,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_VEC_W-1:0]  num_vectors,
    input  logic [1:0]            key_mode,
    input  logic [31:0]           seed,
    aes_roundtrip_sequencer_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_VEC_W-1:0]  pass_count,
    output logic [NUM_VEC_W-1:0]  fail_count,
    output logic [NUM_VEC_W-1:0]  first_fail_idx,
    output logic                  timeout_err,
    output logic                  protocol_err
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    seq_state_t           state, next_state;
    logic [3:0]           gen_cnt;
    logic [383:0]         gen_buf;
    key_mode_t            key_len_q;
    logic [NUM_VEC_W-1:0] num_vec_q;
    logic [NUM_VEC_W-1:0] vec_idx;
    logic [WAIT_W-1:0]    wait_cnt;
    ulogic128             ct_q;
    ulogic128             dec_q;
    logic                 key_valid_q;
    logic [31:0]          lfsr_value;
    logic                 lfsr_load;
    logic                 lfsr_step;

    ulogic128 plaintext;
    logic     in_wait;
    logic     wait_expired;
    logic     last_vec;
    logic     check_pass;
    logic     run_start;

    assign plaintext    = gen_buf[127:0];
    assign in_wait      = (state == S_ENC_WAIT) || (state == S_DEC_WAIT);
    assign wait_expired = in_wait && !bus.resp_valid && (wait_cnt == WAIT_W'(TIMEOUT - 1));
    assign last_vec     = ({1'b0, vec_idx} + 1'b1) == {1'b0, num_vec_q};
    assign check_pass   = (dec_q == plaintext) && (ct_q != plaintext);
    assign run_start    = (state == S_IDLE) && start && !abort;

    aes_lfsr32 #(.LFSR_POLY(LFSR_POLY)) u_lfsr (
        .clk        (clk),
        .resetH     (resetH),
        .load       (lfsr_load),
        .load_value (seed),
        .step       (lfsr_step),
        .value      (lfsr_value)
    );

    always_ff @(posedge clk) begin
        if (resetH) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Abort overrides every transition, including a start sampled in the same cycle.
    always_comb begin
        next_state = state;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    lfsr_load  = 1'b1;
                    next_state = (num_vectors == '0) ? S_DONE : S_GEN;
                end
            end
            S_GEN: begin
                lfsr_step = 1'b1;
                if (gen_cnt == 4'(GEN_WORDS - 1)) begin
                    next_state = S_KEY;
                end
            end
            S_KEY: begin
                if (key_valid_q && bus.key_ready) begin
                    next_state = S_ENC_REQ;
                end
            end
            S_ENC_REQ: begin
                if (bus.req_ready) begin
                    next_state = S_ENC_WAIT;
                end
            end
            S_ENC_WAIT: begin
                if (bus.resp_valid) begin
                    next_state = S_DEC_REQ;
                end else if (wait_expired) begin
                    next_state = S_DONE;
                end
            end
            S_DEC_REQ: begin
                if (bus.req_ready) begin
                    next_state = S_DEC_WAIT;
                end
            end
            S_DEC_WAIT: begin
                if (bus.resp_valid) begin
                    next_state = S_CHECK;
                end else if (wait_expired) begin
                    next_state = S_DONE;
                end
            end
            S_CHECK:  next_state = last_vec ? S_DONE : S_GEN;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
        if (abort) begin
            next_state = S_IDLE;
            lfsr_load  = 1'b0;
            lfsr_step  = 1'b0;
        end
    end

    always_comb begin
        bus.req_valid   = 1'b0;
        bus.req_decrypt = 1'b0;
        bus.req_data    = '0;
        case (state)
            S_ENC_REQ: begin
                bus.req_valid = 1'b1;
                bus.req_data  = plaintext;
            end
            S_DEC_REQ: begin
                bus.req_valid   = 1'b1;
                bus.req_decrypt = 1'b1;
                bus.req_data    = ct_q;
            end
            default: begin
                bus.req_valid = 1'b0;
            end
        endcase
    end

    assign bus.key_valid = key_valid_q;
    assign bus.key_out   = mask_key(gen_buf[383:128], key_len_q);
    assign bus.key_len   = key_len_q;

    // key_valid is registered so it rises one cycle after the last GEN word lands.
    always_ff @(posedge clk) begin
        if (resetH) begin
            gen_cnt        <= '0;
            gen_buf        <= '0;
            key_len_q      <= KEY_AES128;
            num_vec_q      <= '0;
            vec_idx        <= '0;
            wait_cnt       <= '0;
            ct_q           <= '0;
            dec_q          <= '0;
            key_valid_q    <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            timeout_err    <= 1'b0;
            protocol_err   <= 1'b0;
        end else begin
            gen_cnt     <= (state == S_GEN) ? gen_cnt + 4'd1 : 4'd0;
            wait_cnt    <= (in_wait && !abort) ? wait_cnt + 1'b1 : '0;
            key_valid_q <= (state == S_KEY) && !abort && !(key_valid_q && bus.key_ready);
            busy        <= !(next_state == S_IDLE || next_state == S_DONE);

            if (state == S_GEN) begin
                gen_buf <= {gen_buf[351:0], lfsr_next(lfsr_value, LFSR_POLY)};
            end
            if (state == S_ENC_WAIT && bus.resp_valid && !abort) begin
                ct_q <= bus.resp_data;
            end
            if (state == S_DEC_WAIT && bus.resp_valid && !abort) begin
                dec_q <= bus.resp_data;
            end

            if (run_start) begin
                key_len_q      <= key_mode_t'(key_mode);
                num_vec_q      <= num_vectors;
                vec_idx        <= '0;
                pass_count     <= '0;
                fail_count     <= '0;
                first_fail_idx <= '0;
                timeout_err    <= 1'b0;
                protocol_err   <= 1'b0;
                done           <= 1'b0;
            end

            if (state == S_CHECK && !abort) begin
                vec_idx <= vec_idx + 1'b1;
                if (check_pass) begin
                    pass_count <= (&pass_count) ? pass_count : pass_count + 1'b1;
                end else begin
                    fail_count <= (&fail_count) ? fail_count : fail_count + 1'b1;
                    if (fail_count == '0) begin
                        first_fail_idx <= vec_idx;
                    end
                end
            end

            if (wait_expired && !abort) begin
                timeout_err <= 1'b1;
            end
            if (bus.resp_valid && !in_wait) begin
                protocol_err <= 1'b1;
            end
            if (next_state == S_DONE && state != S_DONE) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_roundtrip_sequencer.sv
// Scoreboard bench for aes_roundtrip_sequencer with an XOR-based ideal AES stand-in (10-cycle latency).
module tb_aes_roundtrip_sequencer;
    import aes_tb_pkg::*;

    localparam logic [31:0]  POLY      = 32'h80200003;
    localparam logic [127:0] ENC_CONST = 128'hC3A5_5A3C_0F1E_2D3C_4B5A_6978_8796_A5B4;

    logic        clk = 1'b0;
    logic        resetH = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] num_vectors = '0;
    logic [1:0]  key_mode = '0;
    logic [31:0] seed = '0;
    logic        busy, done, timeout_err, protocol_err;
    logic [15:0] pass_count, fail_count, first_fail_idx;

    aes_roundtrip_sequencer_if bus ();

    aes_roundtrip_sequencer #(.NUM_VEC_W(16), .TIMEOUT(64), .LFSR_POLY(POLY)) dut (
        .clk            (clk),
        .resetH         (resetH),
        .start          (start),
        .abort          (abort),
        .num_vectors    (num_vectors),
        .key_mode       (key_mode),
        .seed           (seed),
        .bus            (bus.master),
        .busy           (busy),
        .done           (done),
        .pass_count     (pass_count),
        .fail_count     (fail_count),
        .first_fail_idx (first_fail_idx),
        .timeout_err    (timeout_err),
        .protocol_err   (protocol_err)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            failures = 0;
    logic [255:0]  exp_key_q[$];
    logic [127:0]  exp_pt_q[$];
    logic          model_on = 1'b1;
    int            flip_vec = -1;
    int            inject_req = 0;
    logic [1:0]    cur_km = '0;

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_step(input logic [31:0] v);
        logic [31:0] r;
        r = {1'b0, v[31:1]};
        if (v[0] == 1'b1) r = r ^ POLY;
        return r;
    endfunction

    // Precomputes every vector's expected key and plaintext, then pulses start.
    task automatic applyStimulus(input logic [31:0] s, input int nv, input logic [1:0] km);
        logic [31:0]  st;
        logic [255:0] k;
        logic [127:0] p;
        exp_key_q.delete();
        exp_pt_q.delete();
        st = (s == 32'h0) ? 32'h1 : s;
        for (int v = 0; v < nv; v++) begin
            k = '0;
            p = '0;
            for (int w = 0; w < 12; w++) begin
                st = model_step(st);
                if (w < 8) k[255 - 32*w -: 32] = st;
                else       p[127 - 32*(w-8) -: 32] = st;
            end
            if (km == 2'd0) k[127:0] = '0;
            if (km == 2'd1) k[63:0]  = '0;
            exp_key_q.push_back(k);
            exp_pt_q.push_back(p);
        end
        cur_km = km;
        @(posedge clk); #1;
        seed = s;
        num_vectors = 16'(nv);
        key_mode = km;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({tag, "_done"}, done, 1);
    endtask

    // Bus monitor, scoreboard consumer and AES stand-in, all sampled on the falling edge.
    initial begin
        logic [255:0] model_key = '0;
        logic [127:0] pend_data = '0;
        int           pend_cnt = 0;
        logic         pending = 1'b0;
        int           dec_idx = 0;
        int           inject_seen = 0;
        bus.resp_valid = 1'b0;
        bus.resp_data  = '0;
        forever begin
            @(negedge clk);
            bus.resp_valid = 1'b0;
            if (start && !busy) dec_idx = 0;
            if (resetH || abort) begin
                pending = 1'b0;
                inject_seen = inject_req;
            end else begin
                if (inject_req != inject_seen) begin
                    inject_seen = inject_req;
                    bus.resp_valid = 1'b1;
                    bus.resp_data  = 128'h1234;
                end
                if (pending) begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        pending = 1'b0;
                        bus.resp_valid = 1'b1;
                        bus.resp_data  = pend_data;
                    end
                end
                if (bus.key_valid && bus.key_ready) begin
                    if (exp_key_q.size() == 0) begin
                        checkOutput("sb_key_unexpected", 1, 0);
                    end else begin
                        checkOutput("sb_key", bus.key_out, exp_key_q.pop_front());
                        checkOutput("key_len", bus.key_len, cur_km);
                    end
                    model_key = bus.key_out;
                end
                if (bus.req_valid && bus.req_ready) begin
                    if (!bus.req_decrypt) begin
                        if (exp_pt_q.size() == 0) checkOutput("sb_pt_unexpected", 1, 0);
                        else checkOutput("sb_plaintext", bus.req_data, exp_pt_q.pop_front());
                    end
                    pend_data = bus.req_data ^ model_key[255:128] ^ model_key[127:0] ^ ENC_CONST;
                    if (bus.req_decrypt && dec_idx == flip_vec) pend_data[0] = ~pend_data[0];
                    if (bus.req_decrypt) dec_idx++;
                    if (model_on) begin
                        pending  = 1'b1;
                        pend_cnt = 10;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int bad;
        logic [255:0] held_key;
        bus.key_ready = 1'b1;
        bus.req_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 resetH = 1'b0;
        @(posedge clk); #1;

        $display("[TB] reset state");
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_key_valid", bus.key_valid, 0);
        checkOutput("rst_req_valid", bus.req_valid, 0);
        checkOutput("rst_key_out", bus.key_out, 0);
        checkOutput("rst_pass", pass_count, 0);

        $display("[TB] four vectors, AES256, seed 1");
        applyStimulus(32'h1, 4, 2'd2);
        n = 0;
        while (bus.key_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("key_valid_latency", n, 13);
        wait_done("run4", 1000);
        checkOutput("run4_busy", busy, 0);
        checkOutput("run4_pass", pass_count, 4);
        checkOutput("run4_fail", fail_count, 0);
        checkOutput("run4_errs", {timeout_err, protocol_err}, 0);
        checkOutput("run4_sb_drain", exp_key_q.size() + exp_pt_q.size(), 0);

        $display("[TB] corrupted decrypt on vector 2, AES192");
        flip_vec = 2;
        applyStimulus(32'hDEADBEEF, 4, 2'd1);
        wait_done("flip", 1000);
        flip_vec = -1;
        checkOutput("flip_pass", pass_count, 3);
        checkOutput("flip_fail", fail_count, 1);
        checkOutput("flip_first_idx", first_fail_idx, 2);

        $display("[TB] zero vectors");
        applyStimulus(32'h55, 0, 2'd2);
        checkOutput("nv0_done", done, 1);
        checkOutput("nv0_busy", busy, 0);
        checkOutput("nv0_counts", {pass_count, fail_count}, 0);

        $display("[TB] zero seed behaves as seed 1");
        applyStimulus(32'h0, 1, 2'd2);
        wait_done("seed0", 500);
        checkOutput("seed0_pass", pass_count, 1);
        checkOutput("seed0_sb_drain", exp_key_q.size(), 0);

        $display("[TB] AES128 with key_ready held low");
        bus.key_ready = 1'b0;
        applyStimulus(32'hA5A5_0001, 1, 2'd0);
        held_key = exp_key_q[0];
        n = 0;
        while (bus.key_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.key_out !== held_key || bus.key_valid !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        checkOutput("key_hold_stable", bad, 0);
        checkOutput("key128_low_zero", bus.key_out[127:0], 0);
        bus.key_ready = 1'b1;
        wait_done("keyhold", 500);
        checkOutput("keyhold_pass", pass_count, 1);

        $display("[TB] silent core, timeout");
        model_on = 1'b0;
        applyStimulus(32'h0BAD_F00D, 1, 2'd2);
        n = 0;
        while (bus.req_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("timeout_cycles", n - 1, 64);
        checkOutput("timeout_err", timeout_err, 1);
        checkOutput("timeout_done", done, 1);
        checkOutput("timeout_counts", {pass_count, fail_count}, 0);
        model_on = 1'b1;

        $display("[TB] abort mid-run");
        applyStimulus(32'h7777, 3, 2'd2);
        repeat (30) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_valids", {bus.key_valid, bus.req_valid}, 0);
        repeat (15) @(posedge clk);
        #1;
        checkOutput("abort_stays_idle", busy, 0);

        $display("[TB] response strobe while idle");
        inject_req++;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("protocol_err", protocol_err, 1);
        checkOutput("protocol_idle", busy, 0);

        $display("[TB] reset during decrypt wait");
        applyStimulus(32'h3141_5926, 2, 2'd2);
        n = 0;
        while (!(bus.req_valid === 1'b1 && bus.req_decrypt === 1'b1) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        resetH = 1'b1;
        @(posedge clk); #1;
        checkOutput("midreset_key_out", bus.key_out, 0);
        checkOutput("midreset_outs",
                    {busy, done, bus.key_valid, bus.req_valid, bus.req_decrypt, bus.key_len,
                     timeout_err, protocol_err, pass_count, fail_count, first_fail_idx, bus.req_data}, 0);
        resetH = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checkOutput("postreset_quiet", {busy, protocol_err}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
